// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM port among four level-request clients.
// One transaction in flight at a time; the request fields are latched at issue and held until the controller answers.
module sdram_port_arbiter #(
   parameter int NCLI    = 4,
   parameter int AW      = 23,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCLI-1:0]     cl_req,
   input  logic [NCLI-1:0]     cl_we,
   input  logic [NCLI*AW-1:0]  cl_addr,
   input  logic [2*NCLI-1:0]   cl_ds,
   input  logic [16*NCLI-1:0]  cl_din,
   output logic [NCLI-1:0]     cl_ack,
   output logic [15:0]         cl_q,
   output logic [1:0]          grant_id,
   output logic                busy,
   output logic                timeout_err,
   output logic                sd_req,
   input  logic                sd_ack,
   output logic                sd_we,
   output logic [AW-1:0]       sd_a,
   output logic [1:0]          sd_ds,
   output logic [15:0]         sd_d,
   input  logic [15:0]         sd_q,
   output logic [1:0]          dbg_state
);

   // Handshake: a client holds cl_req high until it sees its one-cycle cl_ack pulse.
   // Toward the controller, a new transaction is an sd_req toggle; it is complete once sd_ack equals sd_req.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] TO_LIM = TIMEOUT[7:0];

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_issue;
   logic              w_complete;
   logic              w_any;
   logic [1:0]        w_sel;
   logic [1:0]        w_cand;
   logic [7:0]        w_cnt_inc;

   logic              r_sd_req;
   logic [NCLI-1:0]   r_ack;
   logic [15:0]       r_q;
   logic [1:0]        r_grant;
   logic              r_busy;
   logic              r_timeout;
   logic              r_we;
   logic [AW-1:0]     r_a;
   logic [1:0]        r_ds;
   logic [15:0]       r_d;
   logic [7:0]        r_cnt;

   // Scan downward so the client closest after the last grant wins; the last-served one scans last.
   always_comb begin
      w_sel  = r_grant;
      w_any  = 1'b0;
      w_cand = r_grant;
      for (int k = NCLI; k >= 1; k--) begin
         w_cand = r_grant + k[1:0];
         if (cl_req[w_cand]) begin
            w_sel = w_cand;
            w_any = 1'b1;
         end
      end
   end

   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_issue     = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (sd_ack == r_sd_req) begin
               w_complete  = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sd_req  <= sd_ack;
         r_ack     <= '0;
         r_q       <= '0;
         r_grant   <= 2'd3;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_we      <= 1'b0;
         r_a       <= '0;
         r_ds      <= '0;
         r_d       <= '0;
         r_cnt     <= '0;
      end else begin
         r_ack <= '0;
         // Idle re-tracking of sd_ack swallows a completion left over from a transaction cut off by reset.
         if (w_issue) begin
            r_sd_req <= ~sd_ack;
            r_grant  <= w_sel;
            r_busy   <= 1'b1;
            r_we     <= cl_we[w_sel];
            r_a      <= cl_addr[w_sel*AW +: AW];
            r_ds     <= cl_ds[w_sel*2 +: 2];
            r_d      <= cl_din[w_sel*16 +: 16];
         end else if (r_state == IDLE) begin
            r_sd_req <= sd_ack;
         end
         if (w_complete) begin
            if (!r_we) r_q <= sd_q;
            r_ack[r_grant] <= 1'b1;
            r_busy         <= 1'b0;
            r_cnt          <= '0;
         end else if (r_state == WAIT) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= TO_LIM) r_timeout <= 1'b1;
         end
      end
   end

   assign cl_ack      = r_ack;
   assign cl_q        = r_q;
   assign grant_id    = r_grant;
   assign busy        = r_busy;
   assign timeout_err = r_timeout;
   assign sd_req      = r_sd_req;
   assign sd_we       = r_we;
   assign sd_a        = r_a;
   assign sd_ds       = r_ds;
   assign sd_d        = r_d;
   assign dbg_state   = r_state;

endmodule
